// File: rtl/estimate_pkg.sv
// Shared types for the estimate-array command sequencer: array command codes,
// sequencer FSM states and the default array pipeline depth.
package estimate_pkg;

  typedef enum logic [2:0] {
    COM_INI   = 3'd0,
    COM_ACC   = 3'd1,
    COM_POOL  = 3'd2,
    COM_NORM  = 3'd3,
    COM_ACTIV = 3'd4,
    COM_NOP   = 3'd7
  } com_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INI,
    S_ACC,
    S_POOL,
    S_NORM,
    S_ACTV,
    S_DRAIN,
    S_DONE
  } seq_state_e;

  localparam int unsigned DRAIN_DEFAULT = 3;

endpackage

// File: rtl/estimate_seq_cnt.sv
// Nested ACC-word / pool-window / pixel counter for estimate_seq.
// Zero-valued counts are loaded as one; each level reports its last value.
module estimate_seq_cnt #(
  parameter int unsigned ACC_W  = 8,
  parameter int unsigned POOL_W = 3,
  parameter int unsigned PIX_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ACC_W-1:0]  n_acc,
  input  logic [POOL_W-1:0] n_pool,
  input  logic [PIX_W-1:0]  n_pix,
  input  logic              k_step,
  input  logic              w_step,
  input  logic              p_step,
  output logic [ACC_W-1:0]  k,
  output logic              k_last,
  output logic              w_last,
  output logic              p_last
);

  logic [ACC_W-1:0]  acc_max;
  logic [POOL_W-1:0] pool_max;
  logic [PIX_W-1:0]  pix_max;
  logic [POOL_W-1:0] w;
  logic [PIX_W-1:0]  p;

  assign k_last = (k == acc_max);
  assign w_last = (w == pool_max);
  assign p_last = (p == pix_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_max  <= '0;
      pool_max <= '0;
      pix_max  <= '0;
      k        <= '0;
      w        <= '0;
      p        <= '0;
    end else if (load) begin
      acc_max  <= (n_acc  == '0) ? '0 : n_acc  - ACC_W'(1);
      pool_max <= (n_pool == '0) ? '0 : n_pool - POOL_W'(1);
      pix_max  <= (n_pix  == '0) ? '0 : n_pix  - PIX_W'(1);
      k        <= '0;
      w        <= '0;
      p        <= '0;
    end else begin
      // k wraps at the end of every window so each window reuses the same weights
      if (k_step) k <= k_last ? '0 : k + ACC_W'(1);
      if (w_step) w <= w_last ? '0 : w + POOL_W'(1);
      if (p_step) p <= p + PIX_W'(1);
    end
  end

endmodule

// File: rtl/estimate_seq.sv
// Command sequencer feeding the 32-lane binarized estimate array.
// Optional ESTIMATE_SEQ_PERF_EN adds the perf_stall ACC-stall counter output.
module estimate_seq
  import estimate_pkg::*;
#(
  parameter int unsigned ACC_W  = 8,
  parameter int unsigned POOL_W = 3,
  parameter int unsigned PIX_W  = 16,
  parameter int unsigned DRAIN  = DRAIN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ACC_W-1:0]  cfg_n_acc,
  input  logic [POOL_W-1:0] cfg_n_pool,
  input  logic [PIX_W-1:0]  cfg_n_pix,
  input  logic [31:0]       cfg_bias,
  input  logic [15:0]       cfg_w_base,
  input  logic [15:0]       cfg_norm,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic [2:0]        com,
  output logic [15:0]       addr,
  output logic [31:0]       data,
  input  logic [31:0]       activ_in,
  output logic              act_valid,
  output logic [31:0]       act_data,
  output logic              busy,
  output logic              done
`ifdef ESTIMATE_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_stall
`endif
);

  localparam int unsigned    DW         = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN - 1);

  seq_state_e        state_q, state_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [31:0]       bias_q;
  logic [15:0]       w_base_q;
  logic [15:0]       norm_q;

  com_e              com_d;
  logic [15:0]       addr_d;
  logic [31:0]       data_d;
  logic              busy_d;
  logic              done_d;
  logic              cap;
  logic              load;
  logic              k_step;
  logic              w_step;
  logic              p_step;

  logic [ACC_W-1:0]  k;
  logic              k_last;
  logic              w_last;
  logic              p_last;

  estimate_seq_cnt #(
    .ACC_W  (ACC_W),
    .POOL_W (POOL_W),
    .PIX_W  (PIX_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .n_acc  (cfg_n_acc),
    .n_pool (cfg_n_pool),
    .n_pix  (cfg_n_pix),
    .k_step (k_step),
    .w_step (w_step),
    .p_step (p_step),
    .k      (k),
    .k_last (k_last),
    .w_last (w_last),
    .p_last (p_last)
  );

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    com_d    = COM_NOP;
    addr_d   = addr;
    data_d   = data;
    busy_d   = busy;
    done_d   = 1'b0;
    cap      = 1'b0;
    load     = 1'b0;
    k_step   = 1'b0;
    w_step   = 1'b0;
    p_step   = 1'b0;
    in_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = S_INI;
        end
      end
      S_INI: begin
        com_d   = COM_INI;
        data_d  = bias_q;
        state_d = S_ACC;
      end
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          com_d  = COM_ACC;
          data_d = in_data;
          addr_d = w_base_q + 16'(k);
          k_step = 1'b1;
          if (k_last) state_d = S_POOL;
        end
      end
      S_POOL: begin
        com_d   = COM_POOL;
        data_d  = bias_q;
        w_step  = 1'b1;
        state_d = w_last ? S_NORM : S_ACC;
      end
      S_NORM: begin
        com_d   = COM_NORM;
        addr_d  = norm_q;
        state_d = S_ACTV;
      end
      S_ACTV: begin
        com_d   = COM_ACTIV;
        drain_d = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // the array result is taken on the final wait cycle so act_valid
        // lands exactly DRAIN cycles after the ACTIV command is visible
        if (drain_q == DRAIN_LAST) begin
          cap     = 1'b1;
          p_step  = !p_last;
          state_d = p_last ? S_DONE : S_INI;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      drain_q   <= '0;
      bias_q    <= '0;
      w_base_q  <= '0;
      norm_q    <= '0;
      com       <= COM_NOP;
      addr      <= '0;
      data      <= '0;
      act_valid <= 1'b0;
      act_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      com       <= com_d;
      addr      <= addr_d;
      data      <= data_d;
      act_valid <= cap;
      busy      <= busy_d;
      done      <= done_d;
      if (cap) act_data <= activ_in;
      if (load) begin
        bias_q   <= cfg_bias;
        w_base_q <= cfg_w_base;
        norm_q   <= cfg_norm;
      end
    end
  end

`ifdef ESTIMATE_SEQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall <= '0;
    end else if (load) begin
      perf_stall <= '0;
    end else if (state_q == S_ACC && !in_valid && perf_stall != '1) begin
      perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_estimate_seq.sv
// Directed bench for estimate_seq: table of run configurations checked against
// a command-stream model, plus stall, busy-restart and mid-run reset sequences.
module tb_estimate_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  cfg_n_acc;
  logic [2:0]  cfg_n_pool;
  logic [15:0] cfg_n_pix;
  logic [31:0] cfg_bias;
  logic [15:0] cfg_w_base;
  logic [15:0] cfg_norm;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [2:0]  com;
  logic [15:0] addr;
  logic [31:0] data;
  logic [31:0] activ_in;
  logic        act_valid;
  logic [31:0] act_data;
  logic        busy;
  logic        done;
`ifdef ESTIMATE_SEQ_PERF_EN
  logic [31:0] perf_stall;
`endif

  estimate_seq #(
    .ACC_W  (8),
    .POOL_W (3),
    .PIX_W  (16),
    .DRAIN  (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_n_acc  (cfg_n_acc),
    .cfg_n_pool (cfg_n_pool),
    .cfg_n_pix  (cfg_n_pix),
    .cfg_bias   (cfg_bias),
    .cfg_w_base (cfg_w_base),
    .cfg_norm   (cfg_norm),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .com        (com),
    .addr       (addr),
    .data       (data),
    .activ_in   (activ_in),
    .act_valid  (act_valid),
    .act_data   (act_data),
    .busy       (busy),
    .done       (done)
`ifdef ESTIMATE_SEQ_PERF_EN
    ,
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned n_acc, n_pool, n_pix;
    logic [15:0] w_base, norm;
    logic [31:0] bias;
    int unsigned exp_words, exp_cmds, exp_acts;
  } vec_t;

  typedef struct {
    logic [2:0]  com;
    logic [15:0] addr;
    logic [31:0] data;
  } cmd_t;

  typedef struct {
    logic [2:0]  com;
    logic [15:0] addr;
    logic [31:0] data;
    bit          ca, cd;
  } exp_t;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] word_idx;
  int unsigned act_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned cyc = 0;
  int unsigned last_activ_cyc = 0;
  int unsigned last_act_cyc = 0;
  cmd_t        cmdq[$];
  logic [31:0] actq[$];
  int unsigned lat_act[$];
  int unsigned lat_done[$];
  exp_t        expq[$];

  // Source words are numbered by how many have been consumed so far.
  always @(posedge clk) begin
    if (reset) word_idx <= '0;
    else if (in_valid && in_ready) word_idx <= word_idx + 32'd1;
  end
  assign in_data  = 32'hA000_0000 + word_idx;
  assign activ_in = 32'hC0DE_0000 + 32'(act_cnt) * 32'h111;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (com != 3'd7) begin
        cmdq.push_back('{com, addr, data});
        if (com == 3'd4) last_activ_cyc = cyc;
      end
      if (act_valid) begin
        actq.push_back(act_data);
        lat_act.push_back(cyc - last_activ_cyc);
        last_act_cyc = cyc;
        act_cnt++;
      end
      if (done) begin
        lat_done.push_back(cyc - last_act_cyc);
        done_cnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build_exp(input vec_t v, input logic [31:0] w0);
    int unsigned na, np, nx;
    logic [31:0] w;
    logic [15:0] a;
    na = (v.n_acc == 0) ? 1 : v.n_acc;
    np = (v.n_pool == 0) ? 1 : v.n_pool;
    nx = (v.n_pix == 0) ? 1 : v.n_pix;
    w = w0;
    expq.delete();
    for (int unsigned p = 0; p < nx; p++) begin
      expq.push_back('{3'd0, 16'h0, v.bias, 1'b0, 1'b1});
      for (int unsigned q = 0; q < np; q++) begin
        for (int unsigned k = 0; k < na; k++) begin
          a = v.w_base + 16'(k);
          expq.push_back('{3'd1, a, 32'hA000_0000 + w, 1'b1, 1'b1});
          w = w + 32'd1;
        end
        expq.push_back('{3'd2, 16'h0, v.bias, 1'b0, 1'b1});
      end
      expq.push_back('{3'd3, v.norm, 32'h0, 1'b1, 1'b0});
      expq.push_back('{3'd4, 16'h0, 32'h0, 1'b0, 1'b0});
    end
  endtask

  task automatic pulse_start(input vec_t v);
    @(posedge clk); #1;
    cfg_n_acc  = 8'(v.n_acc);
    cfg_n_pool = 3'(v.n_pool);
    cfg_n_pix  = 16'(v.n_pix);
    cfg_bias   = v.bias;
    cfg_w_base = v.w_base;
    cfg_norm   = v.norm;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // junk config after acceptance must not influence the run
    cfg_n_acc  = 8'd9;
    cfg_n_pool = 3'd5;
    cfg_n_pix  = 16'd7;
    cfg_bias   = 32'hDEAD_BEEF;
    cfg_w_base = 16'h7777;
    cfg_norm   = 16'h7777;
  endtask

  task automatic wait_done(input int unsigned d0, input string tag);
    for (int i = 0; i < 5000 && done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_ready_after"}, 32'(in_ready), 0);
  endtask

  task automatic compare_run(input vec_t v, input string tag, input int unsigned c0,
                             input int unsigned a0, input int unsigned l0,
                             input int unsigned n0, input logic [31:0] w0);
    int unsigned ncmd, nact;
    ncmd = cmdq.size() - c0;
    nact = actq.size() - a0;
    chk({tag, "_words"}, word_idx - w0, v.exp_words);
    chk({tag, "_cmds"}, ncmd, v.exp_cmds);
    for (int unsigned i = 0; i < ncmd && i < expq.size(); i++) begin
      chk($sformatf("%s_com%0d", tag, i), 32'(cmdq[c0+i].com), 32'(expq[i].com));
      if (expq[i].ca)
        chk($sformatf("%s_addr%0d", tag, i), 32'(cmdq[c0+i].addr), 32'(expq[i].addr));
      if (expq[i].cd)
        chk($sformatf("%s_data%0d", tag, i), cmdq[c0+i].data, expq[i].data);
    end
    chk({tag, "_acts"}, nact, v.exp_acts);
    for (int unsigned j = 0; j < nact; j++) begin
      chk($sformatf("%s_actdata%0d", tag, j), actq[a0+j],
          32'hC0DE_0000 + 32'(n0 + j) * 32'h111);
      chk($sformatf("%s_actlat%0d", tag, j), lat_act[a0+j], 3);
    end
    if (lat_done.size() > l0) chk({tag, "_donelat"}, lat_done[l0], 1);
  endtask

  task automatic run_vec(input vec_t v, input bit disturb, input string tag);
    int unsigned c0, a0, l0, n0, d0;
    logic [31:0] w0;
    c0 = cmdq.size();
    a0 = actq.size();
    l0 = lat_done.size();
    n0 = act_cnt;
    d0 = done_cnt;
    w0 = word_idx;
    build_exp(v, w0);
    in_valid = 1'b1;
    pulse_start(v);
    chk({tag, "_busy"}, 32'(busy), 1);
    if (disturb) begin
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(d0, tag);
    compare_run(v, tag, c0, a0, l0, n0, w0);
  endtask

  vec_t vecs[5];

  initial begin
    vec_t tv;
    int unsigned d0, c0, a0, l0, n0;
    logic [31:0] w0;

    vecs[0] = '{2, 1, 1, 16'h0100, 16'h0040, 32'h1111_0000, 2, 6, 1};
    vecs[1] = '{3, 4, 1, 16'hFFFE, 16'h0041, 32'h2222_0000, 12, 19, 1};
    vecs[2] = '{1, 2, 3, 16'h0010, 16'h0042, 32'h3333_0000, 6, 21, 3};
    vecs[3] = '{0, 0, 0, 16'h0300, 16'h0043, 32'h4444_0000, 1, 5, 1};
    vecs[4] = '{4, 1, 2, 16'h1234, 16'h0044, 32'h5555_0000, 8, 16, 2};

    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    cfg_n_acc = '0; cfg_n_pool = '0; cfg_n_pix = '0;
    cfg_bias = '0; cfg_w_base = '0; cfg_norm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_com", 32'(com), 7);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_data", data, 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_actv", 32'(act_valid), 0);
    chk("rst_actd", act_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++)
      run_vec(vecs[i], (i == 2), $sformatf("vec%0d", i));

    // in_valid 1,0,0,1 during ACC
    tv = '{2, 1, 1, 16'h0200, 16'h0050, 32'h6666_0000, 2, 6, 1};
    d0 = done_cnt;
    w0 = word_idx;
    in_valid = 1'b0;
    pulse_start(tv);
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("tog_ready0", 32'(in_ready), 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("tog_com0", 32'(com), 1);
    chk("tog_addr0", 32'(addr), 32'h0200);
    chk("tog_data0", data, 32'hA000_0000 + w0);
    chk("tog_ready1", 32'(in_ready), 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("tog_com1", 32'(com), 7);
    chk("tog_ready2", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("tog_com2", 32'(com), 7);
    chk("tog_ready3", 32'(in_ready), 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("tog_com3", 32'(com), 1);
    chk("tog_addr3", 32'(addr), 32'h0201);
    chk("tog_data3", data, 32'hA000_0001 + w0);
    in_valid = 1'b0;
    wait_done(d0, "tog");
    chk("tog_words", word_idx - w0, 2);
`ifdef ESTIMATE_SEQ_PERF_EN
    chk("tog_perf_stall", perf_stall, 2);
`endif

    // reset asserted in the middle of ACC
    tv = '{5, 2, 2, 16'h0400, 16'h0060, 32'h7777_0000, 20, 30, 2};
    a0 = actq.size();
    d0 = done_cnt;
    in_valid = 1'b1;
    pulse_start(tv);
    for (int i = 0; i < 20 && com != 3'd1; i++) begin
      @(posedge clk); #1;
    end
    chk("rstmid_in_acc", 32'(com), 1);
    reset = 1'b1;
    #1;
    chk("rstmid_com", 32'(com), 7);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("rstmid_no_act", actq.size() - a0, 0);
    chk("rstmid_no_done", done_cnt - d0, 0);
    chk("rstmid_idle_com", 32'(com), 7);

    // clean run after the abort
    c0 = cmdq.size();
    a0 = actq.size();
    l0 = lat_done.size();
    n0 = act_cnt;
    d0 = done_cnt;
    w0 = word_idx;
    build_exp(tv, w0);
    pulse_start(tv);
    chk("post_busy", 32'(busy), 1);
    wait_done(d0, "post");
    compare_run(tv, "post", c0, a0, l0, n0, w0);
    if (cmdq.size() > c0) chk("post_first_ini", 32'(cmdq[c0].com), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
